// File: rtl/ifetch_pkg.sv
// ifetch_pkg: fetch FSM encoding and boot PC shared by imem_fetch_ctrl.
// Define IFETCH_LOADER_EN to add the LOAD state for the memory loader.
package ifetch_pkg;

`ifdef IFETCH_LOADER_EN
  typedef enum logic [2:0] {
    BOOT, FETCH, STALL, REDIRECT, LOAD
  } state_t;
`else
  typedef enum logic [2:0] {
    BOOT, FETCH, STALL, REDIRECT
  } state_t;
`endif

  localparam int BOOT_PC = 0;

  function automatic logic is_run(state_t s);
    return (s == FETCH) || (s == STALL);
  endfunction

endpackage

// File: rtl/ifetch_pc.sv
// ifetch_pc: fetch program counter with redirect load and
// increment that wraps from DEPTH-1 back to 0.
module ifetch_pc
  import ifetch_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     inc,
  input  logic                     set,
  input  logic [ADDRESS_WIDTH-1:0] set_val,
  output logic [ADDRESS_WIDTH-1:0] pc
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST =
    ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC0 =
    ADDRESS_WIDTH'(BOOT_PC);
  localparam logic [ADDRESS_WIDTH-1:0] ONE =
    ADDRESS_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc <= PC0;
    end else if (set) begin
      pc <= set_val;
    end else if (inc) begin
      pc <= (pc == LAST) ? '0 : pc + ONE;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch FSM driving a 1-cycle-latency
// instruction RAM. IFETCH_LOADER_EN enables the LOAD (RAM write) path.
module imem_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int ADDRESS_WIDTH = 8,
  parameter int WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  input  logic                     flush,
  input  logic                     load_req,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ack,
  output logic                     ram_en_,
  output logic                     ram_clr,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [WIDTH-1:0]         ram_wdata,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic                     instr_valid
);

  localparam logic [ADDRESS_WIDTH-1:0] PC0 =
    ADDRESS_WIDTH'(BOOT_PC);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_val;
  logic                     pc_set;
  logic                     run;
  logic                     redir_ok;
  logic                     fetch_go;
  logic                     ld;
  logic                     in_load;
  logic                     wr;

`ifdef IFETCH_LOADER_EN
  assign ld      = load_req;
  assign in_load = (state == LOAD);
`else
  logic unused_load;
  assign unused_load = ^{load_req, load_addr, load_data};
  assign ld      = 1'b0;
  assign in_load = 1'b0;
`endif

  assign run      = is_run(state);
  assign redir_ok = run || (state == REDIRECT);
  assign wr       = in_load && load_req;

  // Stall gates the read in the same cycle so InstrD stays put.
  assign fetch_go = run && !flush && !branch_taken
                  && !ld && !stall;

  always_comb begin
    pc_set = 1'b0;
    pc_val = branch_target;
    unique case (1'b1)
      in_load: begin
        pc_set = flush || !load_req;
        pc_val = PC0;
      end
      redir_ok: begin
        pc_set = flush || branch_taken;
        pc_val = flush ? PC0 : branch_target;
      end
      default: ;
    endcase
  end

  ifetch_pc #(
    .DEPTH        (DEPTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_pc (
    .clk    (clk),
    .rst_   (rst_),
    .inc    (fetch_go),
    .set    (pc_set),
    .set_val(pc_val),
    .pc     (pc)
  );

  // Writes only happen in LOAD, where the read port is disabled.
  assign ram_en_   = !(fetch_go || (state == REDIRECT));
  assign ram_clr   = (state == BOOT) || (state == REDIRECT);
  assign ram_addr  = wr ? load_addr : pc;
  assign ram_we    = wr;
  assign ram_wdata = wr ? load_data : '0;
  assign load_ack  = wr;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= BOOT;
      pc_d        <= '0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= FETCH;
        FETCH, STALL: begin
          if (flush || branch_taken) begin
            state       <= REDIRECT;
            instr_valid <= 1'b0;
`ifdef IFETCH_LOADER_EN
          end else if (load_req) begin
            state       <= LOAD;
            instr_valid <= 1'b0;
`endif
          end else if (stall) begin
            state <= STALL;
          end else begin
            state       <= FETCH;
            pc_d        <= pc;
            instr_valid <= 1'b1;
          end
        end
        REDIRECT: begin
          state <= (flush || branch_taken) ? REDIRECT : FETCH;
        end
`ifdef IFETCH_LOADER_EN
        LOAD: begin
          if (flush || !load_req) state <= REDIRECT;
        end
`endif
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed checks of boot, fetch, stall, redirect,
// wrap, flush priority, loader behaviour and asynchronous reset.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        flush;
  logic        load_req;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ack;
  logic        ram_en_;
  logic        ram_clr;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [7:0]  pc_d;
  logic        instr_valid;

  int n_chk  = 0;
  int n_fail = 0;

  imem_fetch_ctrl dut (
    .clk          (clk),
    .rst_         (rst_),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .flush        (flush),
    .load_req     (load_req),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_ack     (load_ack),
    .ram_en_      (ram_en_),
    .ram_clr      (ram_clr),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .pc_d         (pc_d),
    .instr_valid  (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_en"},    32'(ram_en_),     1);
    chk({tag, "_clr"},   32'(ram_clr),     1);
    chk({tag, "_addr"},  32'(ram_addr),    0);
    chk({tag, "_we"},    32'(ram_we),      0);
    chk({tag, "_wdata"}, ram_wdata,        0);
    chk({tag, "_ack"},   32'(load_ack),    0);
    chk({tag, "_pcd"},   32'(pc_d),        0);
    chk({tag, "_iv"},    32'(instr_valid), 0);
  endtask

  initial begin
    rst_          = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    flush         = 1'b0;
    load_req      = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    #2;
    chk_rst("rst");
    #10 rst_ = 1'b1;
    #1;
    chk("boot_clr", 32'(ram_clr), 1);
    chk("boot_en",  32'(ram_en_), 1);

    // first fetch cycle reads address 0
    tick; #1;
    chk("f0_addr", 32'(ram_addr),    0);
    chk("f0_en",   32'(ram_en_),     0);
    chk("f0_clr",  32'(ram_clr),     0);
    chk("f0_iv",   32'(instr_valid), 0);
    for (int i = 1; i <= 5; i++) begin
      tick; #1;
      chk("seq_addr", 32'(ram_addr),    i);
      chk("seq_pcd",  32'(pc_d),        i - 1);
      chk("seq_iv",   32'(instr_valid), 1);
    end

    // stall three cycles at pc=5
    stall = 1'b1;
    #1;
    chk("st_en", 32'(ram_en_), 1);
    chk("st_pcd", 32'(pc_d), 4);
    for (int i = 0; i < 2; i++) begin
      tick; #1;
      chk("st_en",  32'(ram_en_),     1);
      chk("st_pcd", 32'(pc_d),        4);
      chk("st_iv",  32'(instr_valid), 1);
    end
    tick;
    stall = 1'b0;
    #1;
    chk("res_en",   32'(ram_en_),  0);
    chk("res_addr", 32'(ram_addr), 5);
    chk("res_pcd",  32'(pc_d),     4);
    tick; #1;
    chk("res2_addr", 32'(ram_addr), 6);
    chk("res2_pcd",  32'(pc_d),     5);

    // branch overrides stall
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'hF0;
    #1;
    chk("br_en", 32'(ram_en_), 1);
    tick;
    stall        = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("rd_clr",  32'(ram_clr),     1);
    chk("rd_en",   32'(ram_en_),     0);
    chk("rd_iv",   32'(instr_valid), 0);
    chk("rd_addr", 32'(ram_addr),    'hF0);
    tick; #1;
    chk("bf_addr", 32'(ram_addr), 'hF0);
    chk("bf_clr",  32'(ram_clr),  0);
    chk("bf_en",   32'(ram_en_),  0);

    // wrap from 0xFF
    branch_taken  = 1'b1;
    branch_target = 8'hFF;
    tick;
    branch_taken = 1'b0;
    #1;
    chk("w_rd_addr", 32'(ram_addr), 'hFF);
    tick; #1;
    chk("w_ff_addr", 32'(ram_addr), 'hFF);
    tick; #1;
    chk("w_00_addr", 32'(ram_addr),    0);
    chk("w_00_pcd",  32'(pc_d),        'hFF);
    chk("w_00_iv",   32'(instr_valid), 1);

    // flush wins over branch
    flush         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h10;
    tick;
    flush        = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("fl_clr",  32'(ram_clr),  1);
    chk("fl_addr", 32'(ram_addr), 0);
    tick; #1;
    chk("fl_f_addr", 32'(ram_addr), 0);
    chk("fl_f_en",   32'(ram_en_),  0);
    tick; #1;
    chk("fl_n_addr", 32'(ram_addr), 1);
    chk("fl_n_pcd",  32'(pc_d),     0);

`ifdef IFETCH_LOADER_EN
    load_req = 1'b1;
    #1;
    chk("ld_in_en", 32'(ram_en_), 1);
    chk("ld_in_we", 32'(ram_we),  0);
    for (int i = 0; i < 4; i++) begin
      tick;
      load_addr = 8'(i);
      load_data = 32'hA5A5_0000 + 32'(i);
      #1;
      chk("ld_we",    32'(ram_we),   1);
      chk("ld_ack",   32'(load_ack), 1);
      chk("ld_en",    32'(ram_en_),  1);
      chk("ld_addr",  32'(ram_addr), i);
      chk("ld_wdata", ram_wdata,     32'hA5A5_0000 + 32'(i));
      chk("ld_iv",    32'(instr_valid), 0);
    end
    tick;
    load_req = 1'b0;
    #1;
    chk("ld_end_we",  32'(ram_we),   0);
    chk("ld_end_ack", 32'(load_ack), 0);
    tick; #1;
    chk("ld_rd_clr",  32'(ram_clr),  1);
    chk("ld_rd_addr", 32'(ram_addr), 0);
    tick; #1;
    chk("ld_f_addr", 32'(ram_addr), 0);
    chk("ld_f_en",   32'(ram_en_),  0);
    load_req = 1'b1;
    tick;
    load_addr = 8'h07;
    #1;
    chk("ld_pre_we", 32'(ram_we), 1);
`else
    load_req  = 1'b1;
    load_addr = 8'h03;
    load_data = 32'hA5A5_0003;
    #1;
    chk("nl_we",    32'(ram_we),   0);
    chk("nl_ack",   32'(load_ack), 0);
    chk("nl_wdata", ram_wdata,     0);
    chk("nl_en",    32'(ram_en_),  0);
    chk("nl_addr",  32'(ram_addr), 1);
    tick; #1;
    chk("nl2_we",   32'(ram_we),      0);
    chk("nl2_addr", 32'(ram_addr),    2);
    chk("nl2_iv",   32'(instr_valid), 1);
`endif

    // asynchronous reset mid-cycle
    rst_ = 1'b0;
    #1;
    chk_rst("arst");
    load_req = 1'b0;
    #1 rst_ = 1'b1;
    tick; #1;
    chk("ar_f_addr", 32'(ram_addr), 0);
    chk("ar_f_en",   32'(ram_en_),  0);
    tick; #1;
    chk("ar_n_addr", 32'(ram_addr),    1);
    chk("ar_n_pcd",  32'(pc_d),        0);
    chk("ar_n_iv",   32'(instr_valid), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction memory depth in words.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8: word address width.
REQ-003 SHALL have parameter WIDTH, default 32: instruction width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port rst_, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port stall, input, 1: decode stage stalled; hold fetch.
REQ-007 SHALL have ports branch_taken (input, 1) and branch_target (input, ADDRESS_WIDTH): redirect request and target.
REQ-008 SHALL have port flush, input, 1: squash and restart at address 0.
REQ-009 SHALL have ports load_req (input, 1), load_addr (input, ADDRESS_WIDTH) and load_data (input, WIDTH): loader write request.
REQ-010 SHALL have port load_ack, output, 1: loader word accepted this cycle.
REQ-011 SHALL have ports ram_en_ (output, 1), ram_clr (output, 1) and ram_addr (output, ADDRESS_WIDTH): instruction RAM read control, active-low enable.
REQ-012 SHALL have ports ram_we (output, 1) and ram_wdata (output, WIDTH): instruction RAM write strobe and data.
REQ-013 SHALL have ports pc_d (output, ADDRESS_WIDTH) and instr_valid (output, 1): address and validity of the word currently on InstrD.

Function
REQ-014 SHALL implement FSM states BOOT, FETCH, STALL, REDIRECT, LOAD.
REQ-015 BOOT SHALL last exactly one cycle with ram_en_=1 and ram_clr=1, then go to FETCH.
REQ-016 FETCH: SHALL drive ram_en_=0, ram_clr=0, ram_addr=pc; next cycle pc<=pc+1, pc_d<=pc, instr_valid<=1; read latency is 1 cycle.
REQ-017 PC increment SHALL wrap from DEPTH-1 to 0.
REQ-018 stall in FETCH/STALL SHALL enter/hold STALL: ram_en_=1, pc, pc_d and instr_valid held; deassertion returns to FETCH next cycle.
REQ-019 branch_taken SHALL enter REDIRECT: one cycle ram_en_=0, ram_clr=1, pc<=branch_target, instr_valid<=0; then FETCH.
REQ-020 flush SHALL behave as REQ-019 with target 0.
REQ-021 Priority on simultaneous inputs SHALL be flush > branch_taken > load_req > stall.
REQ-022 branch_taken/flush SHALL override stall (squash never suppressed).
REQ-023 load_req in FETCH/STALL SHALL enter LOAD: ram_en_=1, instr_valid<=0.
REQ-024 In LOAD, each cycle with load_req=1 SHALL assert ram_we=1, ram_addr=load_addr, ram_wdata=load_data and load_ack=1 combinationally in the same cycle.
REQ-025 load_req deassertion in LOAD SHALL go to REDIRECT with target 0.
REQ-026 flush in LOAD SHALL also go to REDIRECT with target 0; branch_taken in LOAD SHALL be ignored.
REQ-027 ram_we SHALL never be 1 while ram_en_=0.

Reset
REQ-028 On rst_=0, SHALL go to BOOT with pc=0, pc_d=0, instr_valid=0, ram_en_=1, ram_clr=1, ram_addr=0, ram_we=0, ram_wdata=0 and load_ack=0.
REQ-029 Reset asserted mid-LOAD SHALL abort the write; no ram_we SHALL be issued after rst_ falls.

Configuration
REQ-030 With macro IFETCH_LOADER_EN defined, SHALL implement LOAD per REQ-023..026.
REQ-031 With IFETCH_LOADER_EN undefined, SHALL keep load ports present but ignore load_req, and tie load_ack, ram_we and ram_wdata to 0; the LOAD state SHALL NOT exist.

Structure
REQ-032 SHALL define the FSM state encoding type and the BOOT_PC constant (0) in shared package ifetch_pkg.
REQ-033 SHALL implement the PC register with its wrap/load logic in a sub-module ifetch_pc; the FSM SHALL stay in the top.

Verification
REQ-034 Reset release, no inputs -> ram_addr sequence 0,1,2,3 from cycle 2; pc_d lags by 1; instr_valid=1 from cycle 3.
REQ-035 stall for 3 cycles at pc=5 -> ram_en_=1 for 3 cycles, pc_d held at 4, then fetch resumes at 5.
REQ-036 branch_taken with target 0xF0 while stall=1 -> one cycle ram_clr=1, instr_valid=0, then ram_addr=0xF0.
REQ-037 Fetch from pc=0xFF -> next ram_addr=0x00 (wrap).
REQ-038 load_req for 4 cycles, load_addr=0..3, load_data=0xA5A5_0000+i -> 4 ram_we pulses with load_ack; then REDIRECT and fetch from 0.
REQ-039 flush and branch_taken (target 0x10) in same cycle -> restart at 0x00; without IFETCH_LOADER_EN, load_req=1 -> ram_we stays 0.
